// File: rtl/mmm_pkg.sv
// rtl/mmm_pkg.sv - shared types for the icache read arbiter
//
// Purpose: state and owner encodings used by icache_read_arbiter.
// Ports: none (package).
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    DRAIN
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_PF
  } arb_owner_t;

endpackage

// File: rtl/arb_prio_sel.sv
// rtl/arb_prio_sel.sv - fetch/prefetch winner selection with prefetch aging
//
// Purpose: picks the winner of an arbitration slot. Fetch normally wins.
//   A saturating aging counter tracks how often the prefetcher has lost.
//   When the counter reaches STARVE_LIMIT, the prefetcher wins once.
//   STARVE_LIMIT = 0 disables aging.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   fetch_valid, pf_valid  requester valids
//   enable                 arbitration slot open (arbiter idle)
//   flush                  pipeline flush: no grant, clears aging
//   grant_fetch, grant_pf  one-hot (or zero) grant
module arb_prio_sel #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fetch_valid,
  input  logic pf_valid,
  input  logic enable,
  input  logic flush,
  output logic grant_fetch,
  output logic grant_pf
);

  // Keep at least one bit so that STARVE_LIMIT = 0 still elaborates.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] age_q;
  logic             starved;
  logic             slot_open;

  assign starved   = (STARVE_LIMIT > 0) && (age_q == LIMIT);
  assign slot_open = enable && !flush;

  always_comb begin
    grant_fetch = 1'b0;
    grant_pf    = 1'b0;
    if (slot_open) begin
      if (pf_valid && (starved || !fetch_valid)) begin
        grant_pf = 1'b1;
      end else if (fetch_valid) begin
        grant_fetch = 1'b1;
      end
    end
  end

  // Counts only the fetch grants that actually made the prefetcher wait.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else if (flush || grant_pf) begin
      age_q <= '0;
    end else if (grant_fetch && pf_valid && (age_q != LIMIT)) begin
      age_q <= age_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache_read_arbiter.sv
// rtl/icache_read_arbiter.sv - shares the icache read port between fetch and prefetch
//
// Purpose: one outstanding icache read at a time. The response is routed to
//   the requester that owns the transaction. A flush drains the in-flight
//   read and discards its response.
// Optional: define ICACHE_ARB_PERF_EN to add the perf_* counter outputs.
// Ports:
//   clk_i, rst_i, flush_i                          clock, async reset, flush
//   fetch_req_* / fetch_addr_i / fetch_resp_* /
//   fetch_line_o                                   fetch controller side
//   pf_req_* / pf_addr_i / pf_resp_* / pf_line_o   prefetcher side
//   cache_req_* / cache_addr_o / cache_resp_valid_i /
//   cache_line_i                                   icache read port
//   busy_o                                         transaction in progress
//   perf_fetch_grants_o, perf_pf_grants_o,
//   perf_discards_o                                (ICACHE_ARB_PERF_EN only)
module icache_read_arbiter
  import mmm_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              fetch_req_valid_i,
  output logic              fetch_req_ready_o,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_resp_valid_o,
  output logic [LINE_W-1:0] fetch_line_o,
  input  logic              pf_req_valid_i,
  output logic              pf_req_ready_o,
  input  logic [ADDR_W-1:0] pf_addr_i,
  output logic              pf_resp_valid_o,
  output logic [LINE_W-1:0] pf_line_o,
  output logic              cache_req_valid_o,
  input  logic              cache_req_ready_i,
  output logic [ADDR_W-1:0] cache_addr_o,
  input  logic              cache_resp_valid_i,
  input  logic [LINE_W-1:0] cache_line_i,
  output logic              busy_o
`ifdef ICACHE_ARB_PERF_EN
  ,
  output logic [31:0]       perf_fetch_grants_o,
  output logic [31:0]       perf_pf_grants_o,
  output logic [31:0]       perf_discards_o
`endif
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q;
  logic       discard_q;
  logic       grant_fetch, grant_pf, grant_any;
  logic       arb_enable;
  logic       resp_deliver;
  logic       resp_drop;

  // Gating with rst_i keeps the readies low while reset is held.
  assign arb_enable = (state_q == IDLE) && !rst_i;
  assign grant_any  = grant_fetch || grant_pf;

  arb_prio_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio_sel (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fetch_valid(fetch_req_valid_i),
    .pf_valid   (pf_req_valid_i),
    .enable     (arb_enable),
    .flush      (flush_i),
    .grant_fetch(grant_fetch),
    .grant_pf   (grant_pf)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_any) state_d = ISSUE;
      // The request stays up through a flush; the icache must see it through.
      ISSUE:     if (cache_req_ready_i) state_d = WAIT_RESP;
      WAIT_RESP: begin
        if (cache_resp_valid_i)         state_d = IDLE;
        else if (flush_i || discard_q)  state_d = DRAIN;
      end
      DRAIN:     if (cache_resp_valid_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q      <= OWN_FETCH;
      discard_q    <= 1'b0;
      cache_addr_o <= '0;
    end else begin
      if (grant_any) begin
        cache_addr_o <= grant_pf ? pf_addr_i : fetch_addr_i;
        owner_q      <= grant_pf ? OWN_PF : OWN_FETCH;
      end
      // Remembers a flush seen while the request was still being issued.
      if ((state_q == ISSUE) && flush_i) begin
        discard_q <= 1'b1;
      end else if (((state_q == WAIT_RESP) || (state_q == DRAIN)) && cache_resp_valid_i) begin
        discard_q <= 1'b0;
      end
    end
  end

  always_comb begin
    resp_deliver = (state_q == WAIT_RESP) && cache_resp_valid_i && !flush_i && !discard_q;
    resp_drop    = cache_resp_valid_i &&
                   (((state_q == WAIT_RESP) && (flush_i || discard_q)) || (state_q == DRAIN));

    fetch_req_ready_o  = grant_fetch;
    pf_req_ready_o     = grant_pf;
    cache_req_valid_o  = (state_q == ISSUE);
    busy_o             = (state_q != IDLE);
    fetch_resp_valid_o = resp_deliver && (owner_q == OWN_FETCH);
    pf_resp_valid_o    = resp_deliver && (owner_q == OWN_PF);
    fetch_line_o       = cache_line_i;
    pf_line_o          = cache_line_i;
  end

`ifdef ICACHE_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_grants_o <= '0;
      perf_pf_grants_o    <= '0;
      perf_discards_o     <= '0;
    end else begin
      if (grant_fetch) perf_fetch_grants_o <= perf_fetch_grants_o + 32'd1;
      if (grant_pf)    perf_pf_grants_o    <= perf_pf_grants_o + 32'd1;
      if (resp_drop)   perf_discards_o     <= perf_discards_o + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = resp_drop;
`endif

endmodule

// File: tb/tb_icache_read_arbiter.sv
// tb/tb_icache_read_arbiter.sv - directed self-checking bench for icache_read_arbiter
module tb_icache_read_arbiter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         fetch_req_valid_i;
  logic         fetch_req_ready_o;
  logic [31:0]  fetch_addr_i;
  logic         fetch_resp_valid_o;
  logic [127:0] fetch_line_o;
  logic         pf_req_valid_i;
  logic         pf_req_ready_o;
  logic [31:0]  pf_addr_i;
  logic         pf_resp_valid_o;
  logic [127:0] pf_line_o;
  logic         cache_req_valid_o;
  logic         cache_req_ready_i;
  logic [31:0]  cache_addr_o;
  logic         cache_resp_valid_i;
  logic [127:0] cache_line_i;
  logic         busy_o;
`ifdef ICACHE_ARB_PERF_EN
  logic [31:0]  perf_fetch_grants_o;
  logic [31:0]  perf_pf_grants_o;
  logic [31:0]  perf_discards_o;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] LINE_A5 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;

  always #5 clk = ~clk;

  icache_read_arbiter #(
    .ADDR_W(32),
    .LINE_W(128),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .fetch_req_valid_i  (fetch_req_valid_i),
    .fetch_req_ready_o  (fetch_req_ready_o),
    .fetch_addr_i       (fetch_addr_i),
    .fetch_resp_valid_o (fetch_resp_valid_o),
    .fetch_line_o       (fetch_line_o),
    .pf_req_valid_i     (pf_req_valid_i),
    .pf_req_ready_o     (pf_req_ready_o),
    .pf_addr_i          (pf_addr_i),
    .pf_resp_valid_o    (pf_resp_valid_o),
    .pf_line_o          (pf_line_o),
    .cache_req_valid_o  (cache_req_valid_o),
    .cache_req_ready_i  (cache_req_ready_i),
    .cache_addr_o       (cache_addr_o),
    .cache_resp_valid_i (cache_resp_valid_i),
    .cache_line_i       (cache_line_i),
    .busy_o             (busy_o)
`ifdef ICACHE_ARB_PERF_EN
    ,
    .perf_fetch_grants_o(perf_fetch_grants_o),
    .perf_pf_grants_o   (perf_pf_grants_o),
    .perf_discards_o    (perf_discards_o)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i              = 1'b1;
    flush_i            = 1'b0;
    fetch_req_valid_i  = 1'b1;
    fetch_addr_i       = 32'h0;
    pf_req_valid_i     = 1'b1;
    pf_addr_i          = 32'h0;
    cache_req_ready_i  = 1'b0;
    cache_resp_valid_i = 1'b0;
    cache_line_i       = '0;

    // Reset state, with both requesters valid to show readies stay low.
    tick();
    tick();
    sample();
    check("rst_fetch_ready", fetch_req_ready_o, 0);
    check("rst_pf_ready", pf_req_ready_o, 0);
    check("rst_cache_valid", cache_req_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_addr", cache_addr_o, 0);
    fetch_req_valid_i = 1'b0;
    pf_req_valid_i    = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();

    // Fetch only, addr 0x40, response three cycles after acceptance.
    fetch_req_valid_i = 1'b1;
    fetch_addr_i      = 32'h40;
    cache_req_ready_i = 1'b1;
    sample();
    check("t1_fetch_ready", fetch_req_ready_o, 1);
    check("t1_pf_ready", pf_req_ready_o, 0);
    tick();
    fetch_req_valid_i = 1'b0;
    sample();
    check("t1_cache_valid", cache_req_valid_o, 1);
    check("t1_cache_addr", cache_addr_o, 128'h40);
    check("t1_busy", busy_o, 1);
    tick();
    sample();
    check("t1_cache_valid_drop", cache_req_valid_o, 0);
    tick();
    tick();
    cache_resp_valid_i = 1'b1;
    cache_line_i       = LINE_A5;
    sample();
    check("t1_fetch_resp", fetch_resp_valid_o, 1);
    check("t1_fetch_line", fetch_line_o, LINE_A5);
    check("t1_pf_resp", pf_resp_valid_o, 0);
    tick();
    cache_resp_valid_i = 1'b0;
    sample();
    check("t1_fetch_resp_pulse", fetch_resp_valid_o, 0);
    check("t1_idle", busy_o, 0);

    // Both valid: 8 fetch grants, 9th to prefetch, then fetch again.
    tick();
    fetch_addr_i      = 32'h100;
    pf_addr_i         = 32'h200;
    fetch_req_valid_i = 1'b1;
    pf_req_valid_i    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic exp_pf;
      exp_pf = (i == 8);
      sample();
      check($sformatf("t2_fetch_ready_%0d", i), fetch_req_ready_o, !exp_pf);
      check($sformatf("t2_pf_ready_%0d", i), pf_req_ready_o, exp_pf);
      tick();
      sample();
      check($sformatf("t2_addr_%0d", i), cache_addr_o, exp_pf ? 128'h200 : 128'h100);
      tick();
      cache_resp_valid_i = 1'b1;
      cache_line_i       = 128'(i + 1);
      sample();
      check($sformatf("t2_fetch_resp_%0d", i), fetch_resp_valid_o, !exp_pf);
      check($sformatf("t2_pf_resp_%0d", i), pf_resp_valid_o, exp_pf);
      tick();
      cache_resp_valid_i = 1'b0;
    end
    fetch_req_valid_i = 1'b0;
    pf_req_valid_i    = 1'b0;

    // Stalled ISSUE for 4 cycles with a flush on cycle 2.
    tick();
    cache_req_ready_i = 1'b0;
    fetch_req_valid_i = 1'b1;
    fetch_addr_i      = 32'h300;
    sample();
    check("t3_fetch_ready", fetch_req_ready_o, 1);
    tick();
    fetch_req_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      flush_i           = (c == 2);
      cache_req_ready_i = (c == 4);
      sample();
      check($sformatf("t3_cache_valid_%0d", c), cache_req_valid_o, 1);
      check($sformatf("t3_cache_addr_%0d", c), cache_addr_o, 128'h300);
      tick();
    end
    flush_i = 1'b0;
    sample();
    check("t3_busy_wait", busy_o, 1);
    tick();
    cache_resp_valid_i = 1'b1;
    cache_line_i       = LINE_A5;
    sample();
    check("t3_fetch_resp", fetch_resp_valid_o, 0);
    check("t3_pf_resp", pf_resp_valid_o, 0);
    check("t3_busy_resp", busy_o, 1);
    tick();
    cache_resp_valid_i = 1'b0;
    sample();
    check("t3_busy_after", busy_o, 0);

    // Flush coincident with the response in WAIT_RESP.
    tick();
    cache_req_ready_i = 1'b1;
    fetch_req_valid_i = 1'b1;
    fetch_addr_i      = 32'h400;
    tick();
    fetch_req_valid_i = 1'b0;
    tick();
    cache_resp_valid_i = 1'b1;
    flush_i            = 1'b1;
    sample();
    check("t4_fetch_resp", fetch_resp_valid_o, 0);
    check("t4_pf_resp", pf_resp_valid_o, 0);
    tick();
    cache_resp_valid_i = 1'b0;
    flush_i            = 1'b0;
    sample();
    check("t4_idle", busy_o, 0);
`ifdef ICACHE_ARB_PERF_EN
    check("t4_perf_discards", perf_discards_o, 2);
    check("t4_perf_fetch", perf_fetch_grants_o, 12);
    check("t4_perf_pf", perf_pf_grants_o, 1);
`endif

    // Reset in the middle of WAIT_RESP, then a late response.
    tick();
    fetch_req_valid_i = 1'b1;
    fetch_addr_i      = 32'h500;
    tick();
    fetch_req_valid_i = 1'b0;
    tick();
    sample();
    check("t5_busy_before", busy_o, 1);
    #2;
    rst_i             = 1'b1;
    fetch_req_valid_i = 1'b1;
    pf_req_valid_i    = 1'b1;
    #1;
    check("t5_busy", busy_o, 0);
    check("t5_cache_valid", cache_req_valid_o, 0);
    check("t5_addr", cache_addr_o, 0);
    check("t5_fetch_ready", fetch_req_ready_o, 0);
    check("t5_pf_ready", pf_req_ready_o, 0);
    check("t5_fetch_resp", fetch_resp_valid_o, 0);
`ifdef ICACHE_ARB_PERF_EN
    check("t5_perf_fetch", perf_fetch_grants_o, 0);
`endif
    tick();
    fetch_req_valid_i = 1'b0;
    pf_req_valid_i    = 1'b0;
    rst_i             = 1'b0;
    tick();
    cache_resp_valid_i = 1'b1;
    sample();
    check("t5_late_fetch_resp", fetch_resp_valid_o, 0);
    check("t5_late_pf_resp", pf_resp_valid_o, 0);
    check("t5_late_busy", busy_o, 0);
    tick();
    cache_resp_valid_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
